// File: rtl/r88_bus_responder_if.sv
// Rocket88 external bus request/interrupt signals between core (master) and responder (slave).
// The tristate data bus extD is a board-level net and is carried as a separate inout port.
interface r88_bus_responder_if;
    logic [15:0] extA;
    logic        readMem;
    logic        writeMem;
    logic        irq;

    modport master (output extA, output readMem, output writeMem, input irq);
    modport slave  (input extA, input readMem, input writeMem, output irq);
endinterface

// File: rtl/r88_bus_responder.sv
// Rocket88 bus responder: RAM region plus a 16-byte I/O page with a down-counter timer driving irq.
// Read data is driven 1 cycle after the request edge; no backpressure, every request completes.
module r88_bus_responder #(
    parameter int          RAM_SIZE = 16384,
    parameter logic [15:0] IO_BASE  = 16'hFF00
) (
    input  logic                 sysClock,
    input  logic                 resetReq,
    r88_bus_responder_if.slave   bus,
    inout  wire  [7:0]           extD
);
    localparam int AW = $clog2(RAM_SIZE);

    logic [7:0]    mem_q [RAM_SIZE];

    logic [7:0]    rd_data_q, rd_data_d;
    logic          drive_en_q, drive_en_d;
    logic [15:0]   reload_q, reload_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic [1:0]    status_q, status_d;
    logic [15:0]   count_q, count_d;
    logic [7:0]    snap_q, snap_d;
    logic          irq_q, irq_d;

    logic          rd_req, wr_req, err_req;
    logic          is_ram, is_io;
    logic [3:0]    idx;
    logic [AW-1:0] ram_addr;
    logic [7:0]    io_rd_dat;
    logic          en_rise, expire;

    assign rd_req   = bus.readMem & ~bus.writeMem;
    assign wr_req   = bus.writeMem & ~bus.readMem;
    assign err_req  = bus.readMem & bus.writeMem;
    assign is_ram   = {1'b0, bus.extA} < 17'(RAM_SIZE);
    assign is_io    = bus.extA[15:4] == IO_BASE[15:4];
    assign idx      = bus.extA[3:0];
    assign ram_addr = bus.extA[AW-1:0];

    always_comb begin
        io_rd_dat = 8'h00;
        case (idx)
            4'd0:    io_rd_dat = reload_q[7:0];
            4'd1:    io_rd_dat = reload_q[15:8];
            4'd2:    io_rd_dat = {5'b0, ctrl_q};
            4'd3:    io_rd_dat = {6'b0, status_q};
            4'd4:    io_rd_dat = count_q[7:0];
            4'd5:    io_rd_dat = snap_q;
            default: io_rd_dat = 8'h00;
        endcase
    end

    always_comb begin
        rd_data_d  = rd_data_q;
        drive_en_d = rd_req;
        snap_d     = snap_q;
        reload_d   = reload_q;
        ctrl_d     = ctrl_q;
        status_d   = status_q;
        count_d    = count_q;
        en_rise    = 1'b0;
        expire     = 1'b0;

        if (rd_req) begin
            rd_data_d = is_ram ? mem_q[ram_addr] : (is_io ? io_rd_dat : 8'hFF);
            if (is_io && idx == 4'd4) snap_d = count_q[15:8];
        end

        if (wr_req && is_io) begin
            case (idx)
                4'd0: reload_d[7:0]  = extD;
                4'd1: reload_d[15:8] = extD;
                4'd2: begin
                    ctrl_d  = extD[2:0];
                    en_rise = extD[0] & ~ctrl_q[0];
                end
                4'd3:    status_d = status_q & ~extD[1:0];
                default: ;
            endcase
        end

        // Timer follows the post-write EN so a CTRL write of EN=0 freezes COUNT on the same edge.
        if (en_rise) begin
            count_d = reload_q;
        end else if (ctrl_d[0]) begin
            if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end else begin
                expire = 1'b1;
                if (ctrl_d[2]) count_d = reload_q;
                else           ctrl_d[0] = 1'b0;
            end
        end

        if (expire)  status_d[0] = 1'b1;
        if (err_req) status_d[1] = 1'b1;
        irq_d = status_d[0] & ctrl_d[1];
    end

    always_ff @(posedge sysClock) begin
        if (!resetReq && wr_req && is_ram) mem_q[ram_addr] <= extD;
    end

    always_ff @(posedge sysClock) begin
        if (resetReq) begin
            rd_data_q  <= 8'h00;
            drive_en_q <= 1'b0;
            reload_q   <= 16'h0000;
            ctrl_q     <= 3'b000;
            status_q   <= 2'b00;
            count_q    <= 16'h0000;
            snap_q     <= 8'h00;
            irq_q      <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            drive_en_q <= drive_en_d;
            reload_q   <= reload_d;
            ctrl_q     <= ctrl_d;
            status_q   <= status_d;
            count_q    <= count_d;
            snap_q     <= snap_d;
            irq_q      <= irq_d;
        end
    end

    assign extD    = drive_en_q ? rd_data_q : 8'hzz;
    assign bus.irq = irq_q;
endmodule

// File: tb/tb_r88_bus_responder.sv
// Bench for r88_bus_responder: directed timer/bus scenarios, then random traffic against a behavioural model.
// When the responder should be off the bus the bench drives a known byte, so contention shows up as a wrong value.
module tb_r88_bus_responder;
    localparam int          RAM_SIZE = 16384;
    localparam logic [15:0] IO_BASE  = 16'hFF00;
    localparam logic [7:0]  PROBE    = 8'h81;

    logic       sysClock;
    logic       resetReq;
    logic       tb_drv;
    logic [7:0] tb_dat;
    wire  [7:0] extD;

    r88_bus_responder_if bus ();

    r88_bus_responder #(.RAM_SIZE(RAM_SIZE), .IO_BASE(IO_BASE)) dut (
        .sysClock (sysClock),
        .resetReq (resetReq),
        .bus      (bus.slave),
        .extD     (extD)
    );

    assign extD = tb_drv ? tb_dat : 8'hzz;

    initial begin
        sysClock = 1'b0;
        forever #5 sysClock = ~sysClock;
    end

    int errors = 0;
    int checks = 0;

    // Behavioural model of the responder as seen from the bus
    logic [7:0]  m_ram [RAM_SIZE];
    logic [15:0] m_reload, m_count;
    logic [7:0]  m_snap, m_rdat;
    logic        m_en, m_irqen, m_auto, m_expired, m_buserr, m_irq, m_drive;

    logic [7:0]  obs_d;
    logic        obs_irq;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_io_read(input logic [3:0] i);
        case (i)
            4'd0:    return m_reload[7:0];
            4'd1:    return m_reload[15:8];
            4'd2:    return {5'b0, m_auto, m_irqen, m_en};
            4'd3:    return {6'b0, m_buserr, m_expired};
            4'd4:    return m_count[7:0];
            4'd5:    return m_snap;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic rd, input logic wr,
                              input logic [15:0] a, input logic [7:0] d);
        bit ram, io, start, clear_exp, clear_err, set_exp;
        logic [15:0] old_reload;
        logic [15:0] old_count;
        if (rst) begin
            m_drive = 0; m_irq = 0;
            m_reload = 0; m_count = 0; m_snap = 0;
            m_en = 0; m_irqen = 0; m_auto = 0; m_expired = 0; m_buserr = 0;
            return;
        end
        ram        = int'(a) < RAM_SIZE;
        io         = (a & 16'hFFF0) == IO_BASE;
        old_reload = m_reload;
        old_count  = m_count;
        start = 0; clear_exp = 0; clear_err = 0; set_exp = 0;

        m_drive = rd && !wr;
        if (rd && !wr) begin
            if (ram)     m_rdat = m_ram[a];
            else if (io) m_rdat = m_io_read(a[3:0]);
            else         m_rdat = 8'hFF;
            if (io && a[3:0] == 4'd4) m_snap = old_count[15:8];
        end

        if (wr && !rd) begin
            if (ram) m_ram[a] = d;
            else if (io) begin
                if (a[3:0] == 4'd0) m_reload[7:0]  = d;
                if (a[3:0] == 4'd1) m_reload[15:8] = d;
                if (a[3:0] == 4'd2) begin
                    start   = d[0] && !m_en;
                    m_en    = d[0];
                    m_irqen = d[1];
                    m_auto  = d[2];
                end
                if (a[3:0] == 4'd3) begin
                    clear_exp = d[0];
                    clear_err = d[1];
                end
            end
        end

        if (start) m_count = old_reload;
        else if (m_en) begin
            if (old_count > 0) m_count = old_count - 16'd1;
            else begin
                set_exp = 1;
                if (m_auto) m_count = old_reload;
                else        m_en = 0;
            end
        end

        if (clear_exp) m_expired = 0;
        if (clear_err) m_buserr  = 0;
        if (set_exp)   m_expired = 1;
        if (rd && wr)  m_buserr  = 1;
        m_irq = m_expired && m_irqen;
    endtask

    task automatic cycle(input logic rst, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [7:0] d);
        @(negedge sysClock);
        resetReq     = rst;
        bus.extA     = a;
        bus.readMem  = rd;
        bus.writeMem = wr;
        tb_drv       = !(rd && !wr);
        tb_dat       = wr ? d : PROBE;
        @(posedge sysClock);
        model_edge(rst, rd, wr, a, d);
        #1;
        obs_d   = extD;
        obs_irq = bus.irq;
        chk8("bus_extD", obs_d, m_drive ? m_rdat : tb_dat);
        chk1("bus_irq", obs_irq, m_irq);
    endtask

    // A write straight after a read gets an idle turnaround cycle so the bus is not contended at the write edge.
    task automatic step(input logic rst, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [7:0] d);
        if (m_drive && wr && !rst) cycle(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        cycle(rst, rd, wr, a, d);
    endtask

    task automatic do_rd(input logic [15:0] a);
        step(1'b0, 1'b1, 1'b0, a, 8'h00);
    endtask

    task automatic do_wr(input logic [15:0] a, input logic [7:0] d);
        step(1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic do_idle();
        step(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int k;
        logic [7:0] lo, hi;

        resetReq = 1'b1; bus.extA = '0; bus.readMem = 1'b0; bus.writeMem = 1'b0;
        tb_drv = 1'b1; tb_dat = PROBE;
        m_drive = 0; m_rdat = 0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
        chk1("reset_irq", obs_irq, 1'b0);
        for (int i = 0; i < 6; i++) begin
            do_rd(IO_BASE + 16'(i));
            chk8("reset_ioreg", obs_d, 8'h00);
        end

        // 1: write then read RAM, high-Z around the read
        do_wr(16'h0010, 8'h5A);
        do_wr(16'h0011, 8'hA5);
        do_idle();
        chk8("t1_hiz_before", obs_d, PROBE);
        do_rd(16'h0010);
        chk8("t1_read", obs_d, 8'h5A);
        do_idle();
        chk8("t1_hiz_after", obs_d, PROBE);

        // 2: back-to-back reads and an unmapped read
        do_rd(16'h0010);
        chk8("t2_b2b_0", obs_d, 8'h5A);
        do_rd(16'h0011);
        chk8("t2_b2b_1", obs_d, 8'hA5);
        do_rd(16'h9000);
        chk8("t2_unmapped", obs_d, 8'hFF);

        // 3: auto-reload timer, period 4
        do_wr(IO_BASE + 16'd0, 8'h03);
        do_wr(IO_BASE + 16'd1, 8'h00);
        do_wr(IO_BASE + 16'd2, 8'h07);
        first = 0;
        for (int n = 1; n <= 12 && first == 0; n++) begin
            do_idle();
            if (obs_irq) first = n;
        end
        chk_int("t3_first_expiry", first, 4);
        do_wr(IO_BASE + 16'd3, 8'h01);
        chk1("t3_irq_cleared", obs_irq, 1'b0);
        k = 0;
        for (int n = 1; n <= 12 && k == 0; n++) begin
            do_idle();
            if (obs_irq) k = n;
        end
        chk_int("t3_period", k + 1, 4);
        do_wr(IO_BASE + 16'd2, 8'h00);
        do_wr(IO_BASE + 16'd3, 8'h03);

        // 4: one-shot
        do_wr(IO_BASE + 16'd0, 8'h02);
        do_wr(IO_BASE + 16'd2, 8'h03);
        first = 0;
        for (int n = 1; n <= 12 && first == 0; n++) begin
            do_idle();
            if (obs_irq) first = n;
        end
        chk_int("t4_expiry", first, 3);
        for (int n = 0; n < 4; n++) do_idle();
        do_rd(IO_BASE + 16'd2);
        chk8("t4_ctrl", obs_d, 8'h02);
        do_rd(IO_BASE + 16'd4);
        chk8("t4_count_lo", obs_d, 8'h00);
        do_rd(IO_BASE + 16'd5);
        chk8("t4_count_hi", obs_d, 8'h00);
        do_wr(IO_BASE + 16'd3, 8'h01);
        for (int n = 0; n < 6; n++) do_idle();
        chk1("t4_no_reexpiry", obs_irq, 1'b0);

        // 5: bus error, then clear racing an expiry
        step(1'b0, 1'b1, 1'b1, 16'h0010, 8'h33);
        chk8("t5_err_hiz", obs_d, 8'h33);
        do_rd(16'h0010);
        chk8("t5_ram_kept", obs_d, 8'h5A);
        do_rd(IO_BASE + 16'd3);
        chk8("t5_status_err", obs_d, 8'h02);
        do_wr(IO_BASE + 16'd3, 8'h02);
        do_rd(IO_BASE + 16'd3);
        chk8("t5_status_clr", obs_d, 8'h00);
        do_wr(IO_BASE + 16'd0, 8'h03);
        do_wr(IO_BASE + 16'd2, 8'h07);
        do_idle(); do_idle(); do_idle();
        do_wr(IO_BASE + 16'd3, 8'h01);
        chk1("t5_set_wins_irq", obs_irq, 1'b1);
        do_rd(IO_BASE + 16'd3);
        chk8("t5_set_wins", obs_d, 8'h01);
        do_wr(IO_BASE + 16'd2, 8'h00);
        do_wr(IO_BASE + 16'd3, 8'h03);

        // 6: coherent COUNT read, then reset mid-run
        do_wr(IO_BASE + 16'd0, 8'h34);
        do_wr(IO_BASE + 16'd1, 8'h12);
        do_wr(IO_BASE + 16'd2, 8'h01);
        for (int n = 0; n < 16'h34; n++) do_idle();
        do_rd(IO_BASE + 16'd4);
        lo = obs_d;
        do_rd(IO_BASE + 16'd5);
        hi = obs_d;
        chk_int("t6_count_snap", int'({hi, lo}), 32'h1200);
        do_wr(IO_BASE + 16'd2, 8'h00);
        do_wr(IO_BASE + 16'd0, 8'h00);
        do_wr(IO_BASE + 16'd1, 8'h00);
        do_wr(IO_BASE + 16'd2, 8'h07);
        do_idle();
        chk1("t6_irq_running", obs_irq, 1'b1);
        step(1'b1, 1'b0, 1'b1, 16'h0010, 8'h77);
        chk1("t6_reset_irq", obs_irq, 1'b0);
        chk8("t6_reset_hiz", obs_d, 8'h77);
        do_idle();
        do_rd(IO_BASE + 16'd2);
        chk8("t6_reset_ctrl", obs_d, 8'h00);
        do_rd(16'h0010);
        chk8("t6_ram_survives", obs_d, 8'h5A);

        // Random traffic against the model
        for (int i = 0; i < 64; i++) do_wr(16'(i), 8'($urandom));
        do_wr(IO_BASE + 16'd0, 8'($urandom_range(0, 7)));
        do_wr(IO_BASE + 16'd2, 8'h07);
        for (int i = 0; i < 500; i++) begin
            int op;
            int ix;
            op = $urandom_range(0, 9);
            case (op)
                0, 1: do_wr(16'($urandom_range(0, 63)), 8'($urandom));
                2, 3: do_rd(16'($urandom_range(0, 63)));
                4: begin
                    if ($urandom_range(0, 1) == 0) do_rd(16'($urandom_range(16'h4000, 16'hFEFF)));
                    else                           do_rd(16'($urandom_range(16'hFF10, 16'hFFFF)));
                end
                5: do_rd(IO_BASE + 16'($urandom_range(0, 15)));
                6: begin
                    ix = $urandom_range(0, 15);
                    if (ix == 1 || ix == 2) ix = 0;
                    if (ix == 0) do_wr(IO_BASE, 8'($urandom_range(0, 7)));
                    else         do_wr(IO_BASE + 16'(ix), 8'($urandom));
                end
                7: step(1'b0, 1'b1, 1'b1, 16'($urandom_range(0, 63)), 8'($urandom));
                default: do_idle();
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/r88_bus_responder.md
Name: r88_bus_responder

Overview:
Memory-side responder for the Rocket88 external bus: the target that answers the core's readMem/writeMem requests on extA/extD. It holds a parameterised RAM region and a small memory-mapped I/O page. The I/O page contains a 16-bit down-counter timer that raises the core's maskable interrupt request. It sits on the system board between the core's external pins and memory.

Parameters:
RAM_SIZE, 16384, RAM bytes, mapped at 0x0000..RAM_SIZE-1; power of two, at most 32768
IO_BASE, 16'hFF00, base address of the 16-byte I/O page; low 4 bits must be zero

Ports:
sysClock  input  1  system clock; all state updates on its rising edge
resetReq  input  1  synchronous, active-high reset
extA  input  16  external address bus from the core
extD  inout  8  external data bus; driven only during read response, high-Z otherwise
readMem  input  1  read memory request from the core
writeMem  input  1  write memory request from the core
irq  output  1  maskable interrupt request to the core; level, active-high

Behaviour:
- Reset, on the edge where resetReq=1:
  - driveEn=0 (extD high-Z), irq=0.
  - CTRL, STATUS, RELOAD, COUNT and SNAP are all 0.
  - RAM contents are not reset.
  - resetReq takes priority over every other event in the same cycle.
- Address decode:
  - RAM: extA < RAM_SIZE.
  - IO: extA[15:4]==IO_BASE[15:4]; register index is extA[3:0].
  - Anything else is unmapped: reads return 8'hFF, writes are ignored.
- Read:
  - Edge with readMem=1, writeMem=0: rdData <= selected byte, driveEn <= 1.
  - extD = rdData while driveEn=1. Latency is 1 cycle, so data is valid the cycle after the request edge.
  - Consecutive request cycles are independent reads; the address may change every cycle.
  - driveEn <= 0 on the first edge with readMem=0.
- Write:
  - Edge with writeMem=1, readMem=0: extD is sampled and written to RAM or to the I/O register.
  - driveEn <= 0 on that edge.
- Bus error:
  - Edge with readMem=1 and writeMem=1: no access is performed, driveEn <= 0, STATUS[1] <= 1.
- I/O registers (index, access):
  - 0 RELOAD_LO rw; 1 RELOAD_HI rw.
  - 2 CTRL rw: bit0 EN, bit1 IRQEN, bit2 AUTO; bits 7:3 read 0.
  - 3 STATUS: bit0 EXPIRED, bit1 BUSERR. Writing 1 clears the bit; writing 0 has no effect.
  - 4 COUNT_LO r: returns COUNT[7:0] and latches SNAP <= COUNT[15:8] on the same edge.
  - 5 COUNT_HI r: returns SNAP.
  - Indexes 6..15 read 0x00; writes to them and to 4/5 are ignored.
- Timer, evaluated each edge, not in reset:
  - A CTRL write that takes EN 0->1: COUNT <= RELOAD, no decrement that cycle.
  - Else if EN=1 and COUNT!=0: COUNT <= COUNT-1.
  - Else if EN=1 and COUNT==0:
    - EXPIRED <= 1.
    - If AUTO=1: COUNT <= RELOAD. If AUTO=0: EN <= 0 and COUNT stays 0.
  - Period is RELOAD+1 cycles. RELOAD=0 with AUTO=1 expires every cycle.
  - Writing RELOAD while running does not affect COUNT until the next reload.
  - A CTRL write of EN=0 stops the counter immediately and holds COUNT.
- Simultaneous events:
  - A set event (expiry, bus error) in the same cycle as a STATUS write-1-clear of that bit: the set wins.
- irq is registered: irq <= next EXPIRED & next IRQEN. It deasserts the cycle after a clear or after IRQEN goes 0.
- Read of the STATUS/CTRL/COUNT registers returns the pre-edge value.

Test Plan:
1. Reset, then write 0x5A to 0x0010, then read 0x0010 -> extD=0x5A the cycle after the read edge; high-Z before the read edge and after readMem drops.
2. Back-to-back reads of 0x0010 and 0x0011 (previously 0x5A and 0xA5) with readMem held high -> extD shows 0x5A then 0xA5 on consecutive cycles. Read of 0x9000 -> 0xFF.
3. RELOAD=0x0003, then CTRL=0x07 -> EXPIRED set and irq=1 4 cycles after COUNT loads. Auto-reload repeats every 4 cycles. Write STATUS=0x01 -> irq=0 next cycle.
4. RELOAD=0x0002, CTRL=0x03 (one-shot) -> single expiry, then CTRL reads 0x02 and COUNT stays 0.
5. readMem=writeMem=1 at 0x0010 -> RAM unchanged, extD high-Z, STATUS reads 0x02. A STATUS clear issued in the same cycle as an expiry leaves EXPIRED=1.
6. With the timer running at RELOAD=0x1234, read COUNT_LO then COUNT_HI -> the 16-bit value equals COUNT at the COUNT_LO edge. Assert resetReq mid-run -> irq=0, CTRL=0, extD high-Z next cycle.
